// File: rtl/multi_cycle_controller_pkg.sv
// ============================================================================
//  Module   : multi_cycle_controller_pkg
//  Purpose  : Shared constants and types for the multi-cycle CPU controller:
//             opcode/funct codes, ALUOp codes, state encoding, mux select
//             encodings, instruction class type and control word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_cycle_controller_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct codes (IR[5:0]) that change the control flow or A-input select
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // ALUOp codes; bit 3 selects unsigned compare
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0100;
  localparam logic [3:0] ALUOP_SLT   = 4'b0101;
  localparam logic [3:0] ALUOP_SLTU  = 4'b1101;

  // State encoding
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_IF    = 4'd1;
  localparam logic [3:0] S_ID    = 4'd2;
  localparam logic [3:0] S_MADDR = 4'd3;
  localparam logic [3:0] S_MRD   = 4'd4;
  localparam logic [3:0] S_WBL   = 4'd5;
  localparam logic [3:0] S_MWR   = 4'd6;
  localparam logic [3:0] S_EXR   = 4'd7;
  localparam logic [3:0] S_WBR   = 4'd8;
  localparam logic [3:0] S_EXI   = 4'd9;
  localparam logic [3:0] S_WBI   = 4'd10;
  localparam logic [3:0] S_BR    = 4'd11;
  localparam logic [3:0] S_JMP   = 4'd12;
  localparam logic [3:0] S_JR    = 4'd13;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_RS      = 2'd1;
  localparam logic [1:0] SRCA_SHAMT   = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;
  localparam logic [1:0] WB_ALUOUT    = 2'd0;
  localparam logic [1:0] WB_MDR       = 2'd1;
  localparam logic [1:0] WB_PC        = 2'd2;
  localparam logic [1:0] DST_RT       = 2'd0;
  localparam logic [1:0] DST_RD       = 2'd1;
  localparam logic [1:0] DST_RA       = 2'd2;

  // Instruction class decided in ID and carried through the later states
  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_LW, CL_SW, CL_R, CL_JR, CL_JALR, CL_BEQ,
    CL_J, CL_JAL, CL_ADDI, CL_SLTI, CL_SLTIU, CL_ANDI, CL_LUI
  } inst_class_t;

  // Full datapath control word
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Map opcode/funct to an instruction class (addi and addiu share a class)
  function automatic inst_class_t decode_class(input logic [5:0] op,
                                               input logic [5:0] fn);
    inst_class_t cls;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR)        cls = CL_JR;
        else if (fn == FN_JALR) cls = CL_JALR;
        else                    cls = CL_R;
      end
      OP_LW:              cls = CL_LW;
      OP_SW:              cls = CL_SW;
      OP_BEQ:             cls = CL_BEQ;
      OP_J:               cls = CL_J;
      OP_JAL:             cls = CL_JAL;
      OP_ADDI, OP_ADDIU:  cls = CL_ADDI;
      OP_SLTI:            cls = CL_SLTI;
      OP_SLTIU:           cls = CL_SLTIU;
      OP_ANDI:            cls = CL_ANDI;
      OP_LUI:             cls = CL_LUI;
      default:            cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

  // R-type funct codes the ALU control decoder understands
  function automatic logic funct_known(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_controller_if.sv
// ============================================================================
//  Module   : multi_cycle_controller_if
//  Purpose  : Controller <-> datapath bundle: instruction fields in, control
//             strobes and mux selects out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multi_cycle_controller_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ExtOp;
  logic       LuiOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOp;
  logic [1:0] PCSource;
  logic       Illegal;

  // Controller side
  modport master (
    input  OpCode, Funct,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal
  );

  // Datapath side
  modport slave (
    output OpCode, Funct,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Illegal
  );
endinterface

`default_nettype wire

// File: rtl/multi_cycle_controller_output_decode.sv
// ============================================================================
//  Module   : mcc_output_decode
//  Purpose  : Purely combinational Moore output decode: (state, instruction
//             class, Funct) -> datapath control word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcc_output_decode
  import multi_cycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  inst_class_t        cls,
  input  logic [5:0]         funct,
  output ctrl_t              ctrl
);

  // Every field defaults to 0; each state raises only what it needs
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_ID: begin
        // Branch target computed speculatively into ALUOut
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = (cls == CL_ILLEGAL);
      end
      S_MADDR: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WBL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = WB_MDR;
      end
      S_MWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXR: begin
        // Shifts by immediate take shamt on the A input
        ctrl.alu_src_a = (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
                         ? SRCA_SHAMT : SRCA_RS;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.illegal   = !funct_known(funct);
      end
      S_WBR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RD;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      S_EXI: begin
        ctrl.alu_src_a = SRCA_RS;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = (cls != CL_ANDI);
        ctrl.lui_op    = (cls == CL_LUI);
        case (cls)
          CL_SLTI:  ctrl.alu_op = ALUOP_SLT;
          CL_SLTIU: ctrl.alu_op = ALUOP_SLTU;
          CL_ANDI:  ctrl.alu_op = ALUOP_AND;
          default:  ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      S_WBI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = DST_RT;
        ctrl.mem_to_reg = WB_ALUOUT;
      end
      S_BR: begin
        ctrl.alu_src_a     = SRCA_RS;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        // PC already holds PC+4, which is the link value
        if (cls == CL_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RA;
          ctrl.mem_to_reg = WB_PC;
        end
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_RS;
        if (cls == CL_JALR) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RD;
          ctrl.mem_to_reg = WB_PC;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
// ============================================================================
//  Module   : multi_cycle_controller
//  Purpose  : Main control FSM of the multi-cycle CPU. Sequences each
//             instruction through IF/ID/EX/MEM/WB and drives the datapath.
//             Optional performance counters enabled by macro MCC_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int PERF_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  multi_cycle_controller_if.master   bus
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]          CycleCnt,
  output logic [PERF_W-1:0]          InstCnt
`endif
);

  if (STATE_W < 4 || PERF_W < 1) begin : g_param_check
    $error("multi_cycle_controller: STATE_W must be >= 4 and PERF_W >= 1");
  end

  logic [STATE_W-1:0] state_q, state_d;
  inst_class_t        class_q, class_d, class_live;
  ctrl_t              ctrl;

  assign class_live = decode_class(bus.OpCode, bus.Funct);

  // Class is captured in ID; the decoder sees the live value during ID itself
  always_comb begin
    class_d = (state_q == S_ID) ? class_live : class_q;
  end

  // State and latched class registers; reset abandons any instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      class_q <= CL_ILLEGAL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IDLE:  state_d = S_IF;
      S_IF:    state_d = S_ID;
      S_ID: begin
        case (class_live)
          CL_LW, CL_SW:                   state_d = S_MADDR;
          CL_R:                           state_d = S_EXR;
          CL_JR, CL_JALR:                 state_d = S_JR;
          CL_BEQ:                         state_d = S_BR;
          CL_J, CL_JAL:                   state_d = S_JMP;
          CL_ADDI, CL_SLTI, CL_SLTIU,
          CL_ANDI, CL_LUI:                state_d = S_EXI;
          default:                        state_d = S_IF;
        endcase
      end
      S_MADDR: state_d = (class_q == CL_LW) ? S_MRD : S_MWR;
      S_MRD:   state_d = S_WBL;
      S_EXR:   state_d = S_WBR;
      S_EXI:   state_d = S_WBI;
      default: state_d = S_IF;
    endcase
  end

  mcc_output_decode #(
    .STATE_W (STATE_W)
  ) u_output_decode (
    .state (state_q),
    .cls   (class_d),
    .funct (bus.Funct),
    .ctrl  (ctrl)
  );

  // Drive the control word onto the datapath bundle
  always_comb begin
    bus.PCWrite     = ctrl.pc_write;
    bus.PCWriteCond = ctrl.pc_write_cond;
    bus.IorD        = ctrl.iord;
    bus.MemRead     = ctrl.mem_read;
    bus.MemWrite    = ctrl.mem_write;
    bus.IRWrite     = ctrl.ir_write;
    bus.MemtoReg    = ctrl.mem_to_reg;
    bus.RegDst      = ctrl.reg_dst;
    bus.RegWrite    = ctrl.reg_write;
    bus.ExtOp       = ctrl.ext_op;
    bus.LuiOp       = ctrl.lui_op;
    bus.ALUSrcA     = ctrl.alu_src_a;
    bus.ALUSrcB     = ctrl.alu_src_b;
    bus.ALUOp       = ctrl.alu_op;
    bus.PCSource    = ctrl.pc_source;
    bus.Illegal     = ctrl.illegal;
  end

`ifdef MCC_PERF_CNT_EN
  logic [PERF_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PERF_W-1:0] inst_cnt_q, inst_cnt_d;

  // Cycles outside IDLE; instructions retired on each re-entry into IF
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    if (state_q != S_IDLE) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    if (state_d == S_IF && state_q != S_IDLE) begin
      inst_cnt_d = inst_cnt_q + 1'b1;
    end
  end

  // Counter registers, free-running modulo 2^PERF_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstCnt  = inst_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
// ============================================================================
//  Module   : tb_multi_cycle_controller
//  Purpose  : Self-checking bench for multi_cycle_controller. Expected control
//             words for every cycle of each instruction are queued when the
//             instruction is issued and compared as the FSM steps.
//             Counter checks are compiled in with MCC_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_cycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } cw_t;

  typedef struct {
    string tag;
    cw_t   w;
    bit    idle;
    bit    last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  cw_t  obs;

  multi_cycle_controller_if bus ();

`ifdef MCC_PERF_CNT_EN
  logic [31:0] cyc_cnt, inst_cnt;
  int unsigned m_cyc = 0;
  int unsigned m_inst = 0;
`endif

  multi_cycle_controller dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master)
`ifdef MCC_PERF_CNT_EN
    ,
    .CycleCnt (cyc_cnt),
    .InstCnt  (inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ExtOp,
                bus.LuiOp, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                bus.Illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input cw_t w, input bit idle, input bit last);
    exp_t e;
    e.tag = tag; e.w = w; e.idle = idle; e.last = last;
    exp_q.push_back(e);
  endtask

  // Compare one queued cycle against the current outputs (and counters)
  task automatic check_entry(input exp_t e);
    check_eq(e.tag, 32'(obs), 32'(e.w));
`ifdef MCC_PERF_CNT_EN
    check_eq({e.tag, ".cyc"}, cyc_cnt, m_cyc);
    check_eq({e.tag, ".inst"}, inst_cnt, m_inst);
    if (!e.idle) m_cyc++;
    if (e.last) m_inst++;
`endif
  endtask

  // Pop up to n entries (n < 0: all), one clock each
  task automatic drain(input int n);
    exp_t e;
    int   k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      e = exp_q.pop_front();
      check_entry(e);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic push_idle();
    cw_t w;
    w = '0;
    push("IDLE", w, 1'b1, 1'b0);
  endtask

  // Drive an instruction (called during the cycle it is fetched) and queue
  // its expected control words from IF up to the cycle before the next IF
  task automatic issue(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cw_t w;
    bit  op_ok, fn_ok;
    op_ok = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a,
                       6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
    fn_ok = fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                       6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                       6'h2a, 6'h2b};
    bus.OpCode = op;
    bus.Funct  = fn;
    w = '0; w.mem_read = 1; w.ir_write = 1; w.src_b = 2'd1; w.pc_write = 1;
    push({nm, ".IF"}, w, 1'b0, 1'b0);
    w = '0; w.src_b = 2'd3; w.ext_op = 1; w.illegal = !op_ok;
    push({nm, ".ID"}, w, 1'b0, !op_ok);
    case (op)
      6'h23, 6'h2b: begin
        w = '0; w.src_a = 2'd1; w.src_b = 2'd2; w.ext_op = 1;
        push({nm, ".MADDR"}, w, 1'b0, 1'b0);
        if (op == 6'h23) begin
          w = '0; w.mem_read = 1; w.iord = 1;
          push({nm, ".MRD"}, w, 1'b0, 1'b0);
          w = '0; w.reg_write = 1; w.mem_to_reg = 2'd1;
          push({nm, ".WBL"}, w, 1'b0, 1'b1);
        end else begin
          w = '0; w.mem_write = 1; w.iord = 1;
          push({nm, ".MWR"}, w, 1'b0, 1'b1);
        end
      end
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h09) begin
          w = '0; w.pc_write = 1; w.pc_source = 2'd3;
          if (fn == 6'h09) begin w.reg_write = 1; w.reg_dst = 2'd1; w.mem_to_reg = 2'd2; end
          push({nm, ".JR"}, w, 1'b0, 1'b1);
        end else begin
          w = '0; w.src_b = 2'd0; w.alu_op = 4'b0010; w.illegal = !fn_ok;
          w.src_a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
          push({nm, ".EXR"}, w, 1'b0, 1'b0);
          w = '0; w.reg_write = 1; w.reg_dst = 2'd1;
          push({nm, ".WBR"}, w, 1'b0, 1'b1);
        end
      end
      6'h04: begin
        w = '0; w.src_a = 2'd1; w.alu_op = 4'b0001; w.pc_write_cond = 1; w.pc_source = 2'd1;
        push({nm, ".BR"}, w, 1'b0, 1'b1);
      end
      6'h02, 6'h03: begin
        w = '0; w.pc_write = 1; w.pc_source = 2'd2;
        if (op == 6'h03) begin w.reg_write = 1; w.reg_dst = 2'd2; w.mem_to_reg = 2'd2; end
        push({nm, ".JMP"}, w, 1'b0, 1'b1);
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: begin
        w = '0; w.src_a = 2'd1; w.src_b = 2'd2;
        w.ext_op = (op != 6'h0c);
        w.lui_op = (op == 6'h0f);
        w.alu_op = (op == 6'h0a) ? 4'b0101 :
                   (op == 6'h0b) ? 4'b1101 :
                   (op == 6'h0c) ? 4'b0100 : 4'b0000;
        push({nm, ".EXI"}, w, 1'b0, 1'b0);
        w = '0; w.reg_write = 1;
        push({nm, ".WBI"}, w, 1'b0, 1'b1);
      end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    cw_t  w_if;
    bus.OpCode = 6'h00;
    bus.Funct  = 6'h00;

    // Power-on reset
    repeat (2) @(negedge clk);
    check_eq("reset.outputs", 32'(obs), 32'h0);
`ifdef MCC_PERF_CNT_EN
    check_eq("reset.cyc", cyc_cnt, 32'd0);
    check_eq("reset.inst", inst_cnt, 32'd0);
`endif
    reset = 1'b1;

    // Run a load into MRD, then yank reset mid-instruction
    push_idle();
    issue("lw_a", 6'h23, 6'h00);
    drain(4);
    e = exp_q.pop_front();
    check_entry(e);
    reset = 1'b0;
    #1;
    check_eq("rst_mrd.outputs", 32'(obs), 32'h0);
    exp_q.delete();
`ifdef MCC_PERF_CNT_EN
    m_cyc = 0; m_inst = 0;
    check_eq("rst_mrd.cyc", cyc_cnt, 32'd0);
`endif
    @(negedge clk);
    check_eq("rst_low.outputs", 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Restart: IDLE for one cycle, then the instruction mix
    push_idle();
    issue("lw", 6'h23, 6'h00);      drain(-1);
    issue("sw", 6'h2b, 6'h00);      drain(-1);
    issue("beq", 6'h04, 6'h00);     drain(-1);
    issue("srl", 6'h00, 6'h02);     drain(-1);
    issue("add", 6'h00, 6'h20);     drain(-1);
    issue("rbad", 6'h00, 6'h3f);    drain(-1);
    issue("sltiu", 6'h0b, 6'h00);   drain(-1);
    issue("andi", 6'h0c, 6'h00);    drain(-1);
    issue("slti", 6'h0a, 6'h00);    drain(-1);
    issue("addiu", 6'h09, 6'h00);   drain(-1);
    issue("lui", 6'h0f, 6'h00);     drain(-1);
    issue("jal", 6'h03, 6'h00);     drain(-1);
    issue("j", 6'h02, 6'h00);       drain(-1);
    issue("jr", 6'h00, 6'h08);      drain(-1);
    issue("jalr", 6'h00, 6'h09);    drain(-1);
    issue("ill", 6'h3f, 6'h00);     drain(-1);
    issue("ill2", 6'h3f, 6'h00);    drain(-1);
    issue("beq2", 6'h04, 6'h00);    drain(-1);

    // The FSM must be back in IF after the last instruction
    w_if = '0; w_if.mem_read = 1; w_if.ir_write = 1; w_if.src_b = 2'd1; w_if.pc_write = 1;
    push("final.IF", w_if, 1'b0, 1'b0);
    drain(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
